ila_checker: RTL and testbench
==============================

ILA_CHECKER -- requirements
Module: ila_checker

Interface
REQ-001 SHALL have port clk, input, 1 bit: character clock, the single clock; all logic on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port i_enable, input, 1 bit: high after code-group synchronisation is achieved; low forces IDLE.
REQ-004 SHALL have port i_data, input, 8 bits: received octet, HGFEDCBA.
REQ-005 SHALL have port i_k, input, 1 bit: i_data is a control character.
REQ-006 SHALL have port i_vld, input, 1 bit: octet valid; the FSM and counters advance only when i_vld is high.
REQ-007 SHALL have ports i_F (8 bits) and i_K (5 bits), inputs: local octets-per-frame and frames-per-multiframe, encoded as value-1.
REQ-008 SHALL have port i_ila_multiframe_length, input, 8 bits: ILA length in multiframes, encoded as value-1.
REQ-009 SHALL have port o_cfg, output, 112 bits: captured link-configuration octets; octet n occupies bits [8n+7:8n], n = 0..13.
REQ-010 SHALL have port o_cfg_vld, output, 1 bit: level signal, high when o_cfg is complete.
REQ-011 SHALL have port o_seq_end, output, 1 bit: one-cycle pulse at ILA completion.
REQ-012 SHALL have port o_err, output, 5 bits: sticky error flags.
- bit0: /R/ (K28.0) error.
- bit1: /A/ (K28.3) error.
- bit2: /Q/ (K28.4) error.
- bit3: FCHK mismatch.
- bit4: received F/K differ from i_F/i_K.

Function
REQ-013 SHALL implement the states IDLE, WAIT_R, RX_ILA and DONE.
REQ-014 SHALL leave any state for IDLE on the cycle after i_enable goes low, clearing all counters and accumulators.
REQ-015 SHALL move IDLE -> WAIT_R when i_enable is high.
REQ-016 SHALL remain in WAIT_R while receiving K28.5 (8'hBC, k=1).
REQ-017 SHALL move WAIT_R -> RX_ILA on a valid K28.0 (8'h1C, k=1), counting that octet as position 0 of multiframe 0.
REQ-018 SHALL, in WAIT_R, set o_err[0] and stay in WAIT_R on any valid octet other than K28.5 or K28.0.
REQ-019 SHALL track, in RX_ILA:
- octet-in-frame 0..i_F;
- frame-in-multiframe 0..i_K;
- octet-in-multiframe (11 bits);
- multiframe index (8 bits).
The counters SHALL wrap exactly as frame/multiframe boundaries dictate.
REQ-020 SHALL check each valid octet in RX_ILA against its expected value:
- first octet of every multiframe SHALL be K28.0, otherwise set o_err[0];
- last octet of every multiframe SHALL be K28.3 (8'h7C, k=1), otherwise set o_err[1];
- octet 1 of multiframe 1 SHALL be K28.4 (8'h9C, k=1), otherwise set o_err[2];
- all other octets SHALL have k=0, with content unchecked.
REQ-021 SHALL capture octets 2..15 of multiframe 1 into o_cfg octets 0..13.
REQ-022 SHALL, for those captured octets, set o_err[1] if k=1 was received.
REQ-023 SHALL accumulate a 12-bit field sum over config octets 0..10, adding fields (not raw octets):
- octet 0: DID [7:0];
- octet 1: ADJCNT [7:4], BID [3:0];
- octet 2: ADJDIR [6], PHADJ [5], LID [4:0];
- octet 3: SCR [7], L [4:0];
- octet 4: F [7:0];
- octet 5: K [4:0];
- octet 6: M [7:0];
- octet 7: CS [7:6], N [4:0];
- octet 8: SUBCLASSV [7:5], N' [4:0];
- octet 9: JESDV [7:5], S [4:0];
- octet 10: HD [7], CF [4:0].
REQ-024 SHALL set o_err[3] when the octet-13 value differs from sum[7:0].
REQ-025 SHALL set o_err[4] when received octet 4 differs from i_F or octet 5[4:0] differs from i_K.
REQ-026 SHALL raise o_cfg_vld the cycle after config octet 13 is accepted, and hold it until IDLE.
REQ-027 SHALL, on acceptance of the last octet of multiframe i_ila_multiframe_length, pulse o_seq_end for one cycle on the next edge and enter DONE.
REQ-028 SHALL hold o_cfg, o_cfg_vld and o_err in DONE, leaving DONE only through i_enable low.
REQ-029 SHALL register all outputs; error flags SHALL assert the cycle after the offending octet is accepted.
REQ-030 SHALL ignore octets with i_vld low, producing no counter advance and no checks.
REQ-031 SHALL handle configurations with (i_F+1)*(i_K+1) < 17 octets per multiframe by setting o_err[1] when the first config-region collision occurs.
REQ-032 SHALL handle i_ila_multiframe_length = 0 by ending the ILA without o_cfg_vld.

Reset
REQ-033 SHALL, while rst_n is low:
- enter IDLE;
- drive o_cfg = 0, o_cfg_vld = 0, o_seq_end = 0, o_err = 0;
- clear all counters and the sum.
REQ-034 SHALL, on rst_n assertion mid-ILA, discard the partial capture; the next ILA restarts from WAIT_R.

Verification
REQ-035 SHALL cover a clean ILA (test 1):
- setup: i_F=1, i_K=15 (32 octets/multiframe), length=3, K28.5 preamble;
- stimulus: 4 correct multiframes, DID=8'h5A, FCHK correct;
- response: o_seq_end pulses once, 1 cycle after octet 127; o_cfg_vld=1; o_err=0; o_cfg[7:0]=8'h5A.
REQ-036 SHALL cover an FCHK error: as test 1 with the FCHK octet +1 -> o_err=5'b01000 and o_seq_end still pulses.
REQ-037 SHALL cover a missing /Q/: octet 1 of multiframe 1 = 8'h00, k=0 -> o_err[2]=1.
REQ-038 SHALL cover valid gaps: as test 1 with i_vld low every third cycle -> identical o_cfg, o_err=0, and o_seq_end after the final valid octet.
REQ-039 SHALL cover reset and enable drop: rst_n low during multiframe 2, then a clean ILA -> o_err=0; i_enable low in DONE -> IDLE with o_cfg_vld=0.
REQ-040 SHALL cover an F mismatch: config octet 4 = 8'h03 with i_F=1 -> o_err[4]=1.

Source files
------------

// File: rtl/ila_checker.sv
// JESD204 initial lane alignment (ILA) sequence checker: tracks frame/multiframe
// position, validates control characters, captures the link configuration and checks FCHK.
module ila_checker (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_enable,
    input  logic [7:0]   i_data,
    input  logic         i_k,
    input  logic         i_vld,
    input  logic [7:0]   i_F,
    input  logic [4:0]   i_K,
    input  logic [7:0]   i_ila_multiframe_length,
    output logic [111:0] o_cfg,
    output logic         o_cfg_vld,
    output logic         o_seq_end,
    output logic [4:0]   o_err
);

    typedef enum logic [1:0] {IDLE, WAIT_R, RX_ILA, DONE} state_t;

    state_t         state_q, state_d;
    logic [7:0]     oif_q, oif_d;      // octet in frame
    logic [4:0]     fim_q, fim_d;      // frame in multiframe
    logic [10:0]    oim_q, oim_d;      // octet in multiframe
    logic [7:0]     mf_q, mf_d;        // multiframe index
    logic [11:0]    sum_q, sum_d;
    logic [111:0]   cfg_q, cfg_d;
    logic           cfg_vld_q, cfg_vld_d;
    logic           seq_end_q, seq_end_d;
    logic [4:0]     err_q, err_d;

    logic is_r, is_a, is_q, is_kp, first, last, mf1, in_cfg, take;
    logic [3:0] cfg_idx;

    // Sum of the individual configuration fields carried by config octet idx.
    function automatic logic [8:0] field_sum(input logic [3:0] idx, input logic [7:0] d);
        case (idx)
            4'd0:    return {1'b0, d};
            4'd1:    return 9'(d[7:4]) + 9'(d[3:0]);
            4'd2:    return 9'(d[6]) + 9'(d[5]) + 9'(d[4:0]);
            4'd3:    return 9'(d[7]) + 9'(d[4:0]);
            4'd4:    return {1'b0, d};
            4'd5:    return 9'(d[4:0]);
            4'd6:    return {1'b0, d};
            4'd7:    return 9'(d[7:6]) + 9'(d[4:0]);
            4'd8:    return 9'(d[7:5]) + 9'(d[4:0]);
            4'd9:    return 9'(d[7:5]) + 9'(d[4:0]);
            4'd10:   return 9'(d[7]) + 9'(d[4:0]);
            default: return 9'd0;
        endcase
    endfunction

    assign is_r    = i_k && (i_data == 8'h1C);
    assign is_a    = i_k && (i_data == 8'h7C);
    assign is_q    = i_k && (i_data == 8'h9C);
    assign is_kp   = i_k && (i_data == 8'hBC);
    assign first   = (oim_q == 11'd0);
    assign last    = (oif_q == i_F) && (fim_q == i_K);
    assign mf1     = (mf_q == 8'd1);
    assign in_cfg  = mf1 && (oim_q >= 11'd2) && (oim_q <= 11'd15);
    assign cfg_idx = 4'(oim_q[3:0] - 4'd2);
    // The /R/ that ends WAIT_R is processed as position 0 of multiframe 0.
    assign take    = i_vld && ((state_q == RX_ILA) || ((state_q == WAIT_R) && is_r));

    always_comb begin
        state_d   = state_q;
        oif_d     = oif_q;
        fim_d     = fim_q;
        oim_d     = oim_q;
        mf_d      = mf_q;
        sum_d     = sum_q;
        cfg_d     = cfg_q;
        cfg_vld_d = cfg_vld_q;
        seq_end_d = 1'b0;
        err_d     = err_q;
        if (!i_enable) begin
            state_d   = IDLE;
            oif_d     = '0;
            fim_d     = '0;
            oim_d     = '0;
            mf_d      = '0;
            sum_d     = '0;
            cfg_d     = '0;
            cfg_vld_d = 1'b0;
            err_d     = '0;
        end else begin
            case (state_q)
                IDLE:    state_d = WAIT_R;
                WAIT_R:  if (i_vld && !is_r && !is_kp) err_d[0] = 1'b1;
                default: ;
            endcase
            if (take) begin
                state_d = RX_ILA;
                if (first) begin
                    if (!is_r) err_d[0] = 1'b1;
                end else if (last) begin
                    if (!is_a) err_d[1] = 1'b1;
                    // Multiframe too short: its /A/ lands inside the config region.
                    if (mf1 && (oim_q <= 11'd15)) err_d[1] = 1'b1;
                end else if (mf1 && (oim_q == 11'd1)) begin
                    if (!is_q) err_d[2] = 1'b1;
                end else if (in_cfg) begin
                    if (i_k) err_d[1] = 1'b1;
                    cfg_d[{cfg_idx, 3'b000} +: 8] = i_data;
                    if (cfg_idx <= 4'd10) sum_d = sum_q + 12'(field_sum(cfg_idx, i_data));
                    if ((cfg_idx == 4'd4) && (i_data != i_F)) err_d[4] = 1'b1;
                    if ((cfg_idx == 4'd5) && (i_data[4:0] != i_K)) err_d[4] = 1'b1;
                    if (cfg_idx == 4'd13) begin
                        if (i_data != sum_q[7:0]) err_d[3] = 1'b1;
                        cfg_vld_d = 1'b1;
                    end
                end else if (i_k) begin
                    // Unexpected control character in a data position.
                    err_d[1] = 1'b1;
                end

                if (last) begin
                    oif_d = '0;
                    fim_d = '0;
                    oim_d = '0;
                    mf_d  = mf_q + 8'd1;
                    if (mf_q == i_ila_multiframe_length) begin
                        seq_end_d = 1'b1;
                        state_d   = DONE;
                    end
                end else begin
                    oim_d = oim_q + 11'd1;
                    if (oif_q == i_F) begin
                        oif_d = '0;
                        fim_d = fim_q + 5'd1;
                    end else begin
                        oif_d = oif_q + 8'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            oif_q     <= '0;
            fim_q     <= '0;
            oim_q     <= '0;
            mf_q      <= '0;
            sum_q     <= '0;
            cfg_q     <= '0;
            cfg_vld_q <= 1'b0;
            seq_end_q <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            oif_q     <= oif_d;
            fim_q     <= fim_d;
            oim_q     <= oim_d;
            mf_q      <= mf_d;
            sum_q     <= sum_d;
            cfg_q     <= cfg_d;
            cfg_vld_q <= cfg_vld_d;
            seq_end_q <= seq_end_d;
            err_q     <= err_d;
        end
    end

    assign o_cfg     = cfg_q;
    assign o_cfg_vld = cfg_vld_q;
    assign o_seq_end = seq_end_q;
    assign o_err     = err_q;

endmodule

// File: tb/tb_ila_checker.sv
// Scoreboard bench for ila_checker: each ILA run queues its expected outcome,
// which is popped and compared when o_seq_end fires.
module tb_ila_checker;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_enable;
    logic [7:0]   i_data;
    logic         i_k;
    logic         i_vld;
    logic [7:0]   i_F;
    logic [4:0]   i_K;
    logic [7:0]   i_ila_multiframe_length;
    logic [111:0] o_cfg;
    logic         o_cfg_vld;
    logic         o_seq_end;
    logic [4:0]   o_err;

    ila_checker dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .i_enable                (i_enable),
        .i_data                  (i_data),
        .i_k                     (i_k),
        .i_vld                   (i_vld),
        .i_F                     (i_F),
        .i_K                     (i_K),
        .i_ila_multiframe_length (i_ila_multiframe_length),
        .o_cfg                   (o_cfg),
        .o_cfg_vld               (o_cfg_vld),
        .o_seq_end               (o_seq_end),
        .o_err                   (o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]   err;
        logic         vld;
        logic [111:0] cfg;
        bit           cfg_chk;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] cfg_t [14];
    bit         gaps_en;
    int         cyc_n;

    task automatic chk(input string tag, input logic [111:0] act, input logic [111:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && o_seq_end) begin
            if (sb.size() == 0) begin
                chk("unexpected_seq_end", 112'(1), 112'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_err", 112'(o_err), 112'(e.err));
                chk("sb_cfg_vld", 112'(o_cfg_vld), 112'(e.vld));
                if (e.cfg_chk) chk("sb_cfg", o_cfg, e.cfg);
            end
        end
    end

    // DID 5A, BID 3, LID 1, SCR 1 (+reserved bits set), F=1, K=15 (+reserved bits set),
    // M=1, N=15, SUBCLASSV=1/N'=15, JESDV=1, HD/CF=0; hand-summed FCHK = 0x93.
    task automatic set_cfg_default();
        cfg_t = '{8'h5A, 8'h03, 8'h01, 8'hE3, 8'h01, 8'hEF, 8'h01,
                  8'h0F, 8'h2F, 8'h20, 8'h00, 8'h00, 8'h00, 8'h93};
    endtask

    function automatic logic [111:0] cfg_packed();
        logic [111:0] v;
        for (int n = 0; n < 14; n++) v[8*n +: 8] = cfg_t[n];
        return v;
    endfunction

    task automatic push_exp(input logic [4:0] err, input logic vld, input bit cfg_chk,
                            input logic [111:0] cfg);
        exp_t e;
        e.err = err; e.vld = vld; e.cfg = cfg; e.cfg_chk = cfg_chk;
        sb.push_back(e);
    endtask

    task automatic put(input logic [7:0] d, input logic k);
        if (gaps_en && (cyc_n % 3 == 2)) begin
            @(negedge clk);
            i_vld = 1'b0; i_data = 8'hFF; i_k = 1'b1;
            cyc_n++;
        end
        @(negedge clk);
        i_vld = 1'b1; i_data = d; i_k = k;
        cyc_n++;
    endtask

    // One ILA of (len+1) multiframes of opm octets; rst_mf >= 0 aborts with a reset in that multiframe.
    task automatic run_ila(input int opm, input int len, input bit q_bad, input int rst_mf);
        logic [7:0] d;
        logic       k;
        @(negedge clk);
        i_enable = 1'b1; i_vld = 1'b0;
        i_ila_multiframe_length = 8'(len);
        cyc_n = 0;
        repeat (4) put(8'hBC, 1'b1);
        for (int m = 0; m <= len; m++) begin
            for (int p = 0; p < opm; p++) begin
                if (m == rst_mf && p == 5) begin
                    @(negedge clk);
                    rst_n = 1'b0; i_vld = 1'b0;
                    repeat (2) @(negedge clk);
                    rst_n = 1'b1;
                    return;
                end
                if (p == 0)                       begin d = 8'h1C; k = 1'b1; end
                else if (p == opm - 1)            begin d = 8'h7C; k = 1'b1; end
                else if (m == 1 && p == 1)        begin d = q_bad ? 8'h00 : 8'h9C; k = !q_bad; end
                else if (m == 1 && p >= 2 && p <= 15) begin d = cfg_t[p-2]; k = 1'b0; end
                else                              begin d = 8'(m * 7 + p); k = 1'b0; end
                put(d, k);
                if (q_bad && m == 1 && p == 1) begin
                    @(negedge clk);
                    i_vld = 1'b0;
                    chk("err2_latency", 112'(o_err[2]), 112'(1));
                end
            end
        end
        @(negedge clk);
        i_vld = 1'b0;
        chk("seq_end_latency", 112'(o_seq_end), 112'(1));
        @(negedge clk);
        chk("seq_end_one_cycle", 112'(o_seq_end), 112'(0));
    endtask

    task automatic drop_enable();
        @(negedge clk);
        i_enable = 1'b0; i_vld = 1'b0;
        @(negedge clk);
        chk("idle_cfg_vld", 112'(o_cfg_vld), 112'(0));
        chk("idle_err", 112'(o_err), 112'(0));
    endtask

    initial begin
        rst_n = 1'b0; i_enable = 1'b0; i_data = '0; i_k = 1'b0; i_vld = 1'b0;
        i_F = 8'd1; i_K = 5'd15; i_ila_multiframe_length = 8'd3;
        gaps_en = 1'b0; cyc_n = 0;
        set_cfg_default();
        repeat (3) @(negedge clk);
        chk("rst_cfg", o_cfg, 112'(0));
        chk("rst_cfg_vld", 112'(o_cfg_vld), 112'(0));
        chk("rst_seq_end", 112'(o_seq_end), 112'(0));
        chk("rst_err", 112'(o_err), 112'(0));
        rst_n = 1'b1;

        // Clean ILA, then DONE must ignore further octets.
        push_exp(5'b00000, 1'b1, 1'b1, cfg_packed());
        run_ila(32, 3, 1'b0, -1);
        chk("did", 112'(o_cfg[7:0]), 112'(8'h5A));
        repeat (3) put(8'h1C, 1'b1);
        @(negedge clk);
        i_vld = 1'b0;
        chk("done_hold_vld", 112'(o_cfg_vld), 112'(1));
        chk("done_hold_err", 112'(o_err), 112'(0));
        drop_enable();

        // FCHK off by one.
        cfg_t[13] = 8'h94;
        push_exp(5'b01000, 1'b1, 1'b1, cfg_packed());
        run_ila(32, 3, 1'b0, -1);
        drop_enable();
        set_cfg_default();

        // Missing /Q/.
        push_exp(5'b00100, 1'b1, 1'b1, cfg_packed());
        run_ila(32, 3, 1'b1, -1);
        drop_enable();

        // i_vld gaps every third cycle.
        gaps_en = 1'b1;
        push_exp(5'b00000, 1'b1, 1'b1, cfg_packed());
        run_ila(32, 3, 1'b0, -1);
        gaps_en = 1'b0;
        drop_enable();

        // Reset in multiframe 2, then a clean ILA.
        run_ila(32, 3, 1'b0, 2);
        @(negedge clk);
        chk("post_rst_err", 112'(o_err), 112'(0));
        chk("post_rst_cfg_vld", 112'(o_cfg_vld), 112'(0));
        push_exp(5'b00000, 1'b1, 1'b1, cfg_packed());
        run_ila(32, 3, 1'b0, -1);
        drop_enable();

        // F mismatch: octet 4 = 3 with FCHK recomputed (0x93 + 2).
        cfg_t[4] = 8'h03; cfg_t[13] = 8'h95;
        push_exp(5'b10000, 1'b1, 1'b1, cfg_packed());
        run_ila(32, 3, 1'b0, -1);
        drop_enable();
        set_cfg_default();

        // Single-multiframe ILA: ends without configuration.
        push_exp(5'b00000, 1'b0, 1'b1, 112'(0));
        run_ila(32, 0, 1'b0, -1);
        drop_enable();

        // 8 octets per multiframe: the /A/ of multiframe 1 collides with config octet 5.
        i_F = 8'd0; i_K = 5'd7; cfg_t[4] = 8'h00;
        push_exp(5'b00010, 1'b0, 1'b0, 112'(0));
        run_ila(8, 1, 1'b0, -1);
        drop_enable();
        i_F = 8'd1; i_K = 5'd15;
        set_cfg_default();

        repeat (4) @(negedge clk);
        chk("sb_empty", 112'(sb.size()), 112'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
